// File: rtl/pipelined_add_sub32.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub32
//
// Two-stage pipelined adder/subtractor for the execute stage. It produces the
// raw sum and the signed overflow flag that set-less-than needs, and it also
// forms the final ADD/SUB/SLT result with carryout, overflow and zero flags.
//
// The carry chain is split in two. Stage 1 adds the low SPLIT bits and
// registers the carry out of that slice together with the untouched upper
// operand slices. Stage 2 finishes the upper slice, derives the flags and
// registers the architectural outputs.
//
// Ports
//   clk        clock, rising edge active
//   rst_n      asynchronous active-low reset
//   in_valid   operands/op valid
//   in_ready   stage 1 can accept this cycle
//   op         00=ADD, 01=SUB, 10=SLT, 11=reserved (behaves as ADD)
//   a, b       signed operands
//   flush      drops every in-flight operation at the next edge
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   result     ADD/SUB: sum, SLT: {0..0, less-than bit}
//   sum        raw adder sum (a+b or a-b) regardless of op
//   carryout   carry out of the MSB (0 for SLT)
//   overflow   signed overflow of the add/sub (0 for SLT)
//   zero       result == 0
// ---------------------------------------------------------------------------
module pipelined_add_sub32 #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int HI = WIDTH - SPLIT;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SLT = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s2_free;
  logic w_s1_adv;
  logic w_accept;

  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  // flush blocks acceptance so the same-cycle input is dropped with the rest
  assign in_ready  = !flush && (!r_s1_valid || w_s2_free);
  assign w_accept  = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Stage 1: operand conditioning and low-slice addition
  // -------------------------------------------------------------------------
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [SPLIT:0]   w_lo_full;

  // SUB and SLT compute a + ~b + 1; ADD and the reserved code add directly.
  assign w_sub = (op == OP_SUB) || (op == OP_SLT);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
      assign w_b_eff[gi] = b[gi] ^ w_sub;
    end
  endgenerate

  assign w_lo_full = {1'b0, a[SPLIT-1:0]} + {1'b0, w_b_eff[SPLIT-1:0]}
                   + {{SPLIT{1'b0}}, w_sub};

  logic [SPLIT-1:0] r_s1_lo_sum;
  logic             r_s1_lo_carry;
  logic [HI-1:0]    r_s1_a_hi;
  logic [HI-1:0]    r_s1_b_hi;
  logic             r_s1_a_msb;
  logic             r_s1_b_msb;
  logic [1:0]       r_s1_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_lo_sum   <= '0;
      r_s1_lo_carry <= 1'b0;
      r_s1_a_hi     <= '0;
      r_s1_b_hi     <= '0;
      r_s1_a_msb    <= 1'b0;
      r_s1_b_msb    <= 1'b0;
      r_s1_op       <= 2'b00;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_accept) begin
        r_s1_lo_sum   <= w_lo_full[SPLIT-1:0];
        r_s1_lo_carry <= w_lo_full[SPLIT];
        r_s1_a_hi     <= a[WIDTH-1:SPLIT];
        r_s1_b_hi     <= w_b_eff[WIDTH-1:SPLIT];
        r_s1_a_msb    <= a[WIDTH-1];
        r_s1_b_msb    <= w_b_eff[WIDTH-1];
        r_s1_op       <= op;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: upper-slice addition, flags and result formation
  // -------------------------------------------------------------------------
  logic [HI:0]      w_hi_full;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry_msb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_carry_out;
  logic             w_ovf_out;
  logic             w_zero;

  assign w_hi_full   = {1'b0, r_s1_a_hi} + {1'b0, r_s1_b_hi}
                     + {{HI{1'b0}}, r_s1_lo_carry};
  assign w_sum       = {w_hi_full[HI-1:0], r_s1_lo_sum};
  assign w_carry_msb = w_hi_full[HI];
  // Overflow: both effective operands share a sign that the sum does not.
  assign w_ovf       = (r_s1_a_msb == r_s1_b_msb) && (w_sum[WIDTH-1] != r_s1_a_msb);

  always_comb begin
    w_result    = w_sum;
    w_carry_out = w_carry_msb;
    w_ovf_out   = w_ovf;
    if (r_s1_op == OP_SLT) begin
      // a < b (signed) exactly when the sign of a-b disagrees with overflow
      w_result    = '0;
      w_result[0] = w_sum[WIDTH-1] ^ w_ovf;
      w_carry_out = 1'b0;
      w_ovf_out   = 1'b0;
    end
  end

  assign w_zero = (w_result == '0);

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      // A flush wins over consumption: the output is discarded, not delivered.
      if (flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s1_adv) begin
        r_s2_valid <= 1'b1;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end

      // Data only moves on an advance, so it stays stable under backpressure.
      if (w_s1_adv && !flush) begin
        r_result <= w_result;
        r_sum    <= w_sum;
        r_carry  <= w_carry_out;
        r_ovf    <= w_ovf_out;
        r_zero   <= w_zero;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign sum       = r_sum;
  assign carryout  = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

// File: doc/pipelined_add_sub32.md
Name: pipelined_add_sub32

Overview:
- Two-stage pipelined 32-bit adder/subtractor in the execute stage.
- Directly upstream of the set-less-than logic: it produces the signed sum and overflow flag that the SLT stage turns into bit 0 of the result.
- Also produces the final ADD/SUB/SLT result, carryout, overflow and zero flags.
- Uses a valid/ready handshake on both sides, with backpressure and flush.

Parameters:
- WIDTH, 32, operand/result width.
- SPLIT, 16, bits added in stage 1 (low slice). Stage 2 adds WIDTH-SPLIT bits. Legal range 1..WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  stage 1 can accept this cycle.
- op  in  2  00=ADD, 01=SUB, 10=SLT, 11=reserved (treated as ADD).
- a  in  WIDTH  operand A, signed.
- b  in  WIDTH  operand B, signed.
- flush  in  1  discard all in-flight operations.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  ADD/SUB: sum; SLT: {0..0, sum[MSB]^overflow}.
- sum  out  WIDTH  raw adder sum (a+b or a-b), regardless of op.
- carryout  out  1  carry out of MSB; 0 for SLT.
- overflow  out  1  signed overflow of the add/sub; 0 for SLT.
- zero  out  1  result == 0.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0. All outputs 0, including out_valid, result, sum, carryout, overflow and zero. in_ready is 1 once rst_n is high.
- Subtract: for SUB and SLT, b is inverted and carry-in is 1; for ADD, carry-in is 0.
- Stage 1 (on accept):
  - Register low sum = a[SPLIT-1:0] + b'[SPLIT-1:0] + cin, and the carry out of bit SPLIT-1.
  - Register a/b' upper slices, a[MSB] and b'[MSB] sign bits, and op.
  - Set s1_valid=1.
- Stage 2 (on advance):
  - Upper sum = upper slices + stage-1 carry.
  - carry_msb = carry out of bit WIDTH-1.
  - ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]).
  - Register sum, result, flags; set s2_valid=1.
- Output mapping: out_valid=s2_valid. result/sum/flags come from stage-2 registers and are held stable while out_valid=1 && out_ready=0.
- Handshake:
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !flush && (!s1_valid || s2_free).
  - Accept = in_valid && in_ready.
- Latency: exactly 2 cycles from accept to out_valid with no backpressure.
- Throughput: 1 op/cycle sustained when out_ready=1.
- Backpressure: out_ready=0 with both stages full gives in_ready=0. No data is lost or duplicated.
- Drain: when s2 empties with no s1 advance, s2_valid drops to 0 on the next edge.
- Flush (sampled at edge): clears s1_valid and s2_valid at that edge. The same-cycle in_valid is not accepted. The current output is not considered consumed, even if out_ready=1. Data registers may hold stale values but out_valid=0.
- Flags:
  - zero is computed on result, not on sum.
  - For SLT: carryout=0, overflow=0, result[WIDTH-1:1]=0.
- Wrap-around: the sum is modulo 2^WIDTH. The carry out of the MSB is reported, never saturated.
- Reserved op 11: behaves exactly as ADD.
- Reset asserted mid-operation: in-flight ops are dropped immediately; nothing is emitted after release until a new accept.

Test Plan:
- ADD, a=0x7FFFFFFF, b=0x00000001, out_ready=1 -> 2 cycles later: result=0x80000000, overflow=1, carryout=0, zero=0.
- SUB, a=5, b=5 -> result=0, zero=1, carryout=1, overflow=0.
- SLT, a=0x80000000, b=1 -> result=1 (sum=0x7FFFFFFF, overflow internal), overflow=0, carryout=0. Also SLT a=3, b=-2 -> result=0.
- Low-to-high carry propagation: ADD a=0x0000FFFF, b=0x00000001 -> result=0x00010000. ADD a=0xFFFFFFFF, b=1 -> result=0, carryout=1, zero=1.
- Backpressure and throughput:
  - Stream 4 back-to-back ops with out_ready held 0 from cycle 2 -> in_ready falls after two accepts.
  - out_valid holds with result stable.
  - Releasing out_ready drains all 4 in order with no loss.
- Flush/reset:
  - flush asserted with both stages full and in_valid=1 -> next cycle out_valid=0, and the input is not accepted.
  - rst_n pulsed low mid-stream -> out_valid=0 immediately, and no stale result appears after release.
